instruction_fetch: RTL and testbench

- IF stage of the RV32I core, directly upstream of the combinational word-aligned instruction memory.
- Owns the program counter and drives the memory address.
- Captures the returned instruction word into an IF/ID register with a valid/ready handshake to decode.
- Takes branch/jump redirects and halt requests from execute/control.

---
 rtl/instruction_fetch.sv | 135 +++++++++++++
 tb/tb_instruction_fetch.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// IF stage: owns the PC, fetches from combinational imem, holds the IF/ID register.
// FETCH_MISALIGN_TRAP_EN: a misaligned redirect traps instead of being aligned.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    input  logic        id_ready,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic        trap_valid,
    output logic [31:0] trap_pc
`endif
);

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HALT
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        TRAP
`endif
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] ipc_q, ipc_d;
    logic [31:0] ip4_q, ip4_d;
    logic        accept;
    logic [31:0] pc_inc;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        tvalid_q, tvalid_d;
    logic [31:0] tpc_q, tpc_d;
`endif

    assign imem_addr = pc_q;
    assign accept    = !valid_q || id_ready;
    assign pc_inc    = pc_q + 32'd4;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        ip4_d   = ip4_q;
`ifdef FETCH_MISALIGN_TRAP_EN
        tvalid_d = tvalid_q;
        tpc_d    = tpc_q;
`endif
        unique case (state_q)
            BOOT: state_d = halt ? HALT : RUN;
            RUN, HALT: begin
                if (redirect_valid) begin
                    valid_d = 1'b0;
                    instr_d = NOP_INSTR;
`ifdef FETCH_MISALIGN_TRAP_EN
                    if (redirect_pc[1:0] != 2'b00) begin
                        tvalid_d = 1'b1;
                        tpc_d    = redirect_pc;
                        state_d  = TRAP;
                    end else
`endif
                    begin
                        pc_d    = redirect_pc & ~32'h3;
                        state_d = halt ? HALT : RUN;
                    end
                end else if (halt || state_q == HALT) begin
                    // drain only; resuming from HALT costs one idle RUN entry
                    if (id_ready) valid_d = 1'b0;
                    state_d = halt ? HALT : RUN;
                end else if (accept) begin
                    instr_d = imem_rdata;
                    ipc_d   = pc_q;
                    ip4_d   = pc_inc;
                    valid_d = 1'b1;
                    pc_d    = pc_inc;
                end
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            TRAP: state_d = TRAP;
`endif
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
            ipc_q   <= 32'd0;
            ip4_q   <= 32'd0;
`ifdef FETCH_MISALIGN_TRAP_EN
            tvalid_q <= 1'b0;
            tpc_q    <= 32'd0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            ip4_q   <= ip4_d;
`ifdef FETCH_MISALIGN_TRAP_EN
            tvalid_q <= tvalid_d;
            tpc_q    <= tpc_d;
`endif
        end
    end

    assign if_valid    = valid_q;
    assign if_instr    = instr_q;
    assign if_pc       = ipc_q;
    assign if_pc_plus4 = ip4_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    assign trap_valid  = tvalid_q;
    assign trap_pc     = tpc_q;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: scoreboard of expected fetches plus direct checks.
// Memory word at byte address a is addi x1,x0,(a>>2) truncated to 12 bits.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        halt = 1'b0;
    logic        id_ready = 1'b1;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        trap_valid;
    logic [31:0] trap_pc;
`endif

    localparam logic [31:0] NOP = 32'h0000_0013;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] sb_q[$];

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_at(input logic [31:0] a);
        return ((a >> 2) << 20) | 32'h0000_0093;
    endfunction

    assign imem_rdata = instr_at(imem_addr);

    instruction_fetch dut (
        .clk           (clk),
        .rst           (rst),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .halt          (halt),
        .id_ready      (id_ready),
        .if_valid      (if_valid),
        .if_instr      (if_instr),
        .if_pc         (if_pc),
        .if_pc_plus4   (if_pc_plus4)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .trap_valid    (trap_valid),
        .trap_pc       (trap_pc)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 32'd0;
        halt = 1'b0;
        id_ready = 1'b1;
        sb_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic sb_done();
        chk("sb_left", 32'(sb_q.size()), 32'd0);
    endtask

    // every IF->ID transfer must match the next expected fetch
    always @(negedge clk) begin
        if (!rst && if_valid && id_ready) begin
            if (sb_q.size() == 0) begin
                chk("sb_extra", 32'd0, 32'd1);
            end else begin
                logic [31:0] e;
                e = sb_q.pop_front();
                chk("sb_pc", if_pc, e);
                chk("sb_instr", if_instr, instr_at(e));
                chk("sb_pc4", if_pc_plus4, e + 32'd4);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset, sequential fetch, stall
        do_reset();
        chk("rst_valid", 32'(if_valid), 32'd0);
        chk("rst_instr", if_instr, NOP);
        chk("rst_pc", if_pc, 32'd0);
        chk("rst_pc4", if_pc_plus4, 32'd0);
        chk("rst_addr", imem_addr, 32'd0);
        sb_q.push_back(32'd0);
        sb_q.push_back(32'd4);
        sb_q.push_back(32'd8);
        sb_q.push_back(32'd12);
        step();
        chk("boot_valid", 32'(if_valid), 32'd0);
        step();
        step();
        step();
        id_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("stall_pc", if_pc, 32'd8);
            chk("stall_instr", if_instr, instr_at(32'd8));
            chk("stall_addr", imem_addr, 32'd12);
            chk("stall_valid", 32'(if_valid), 32'd1);
            step();
        end
        id_ready = 1'b1;
        step();
        chk("unstall_pc", if_pc, 32'd12);
        step();
        id_ready = 1'b0;
        sb_done();
        // asynchronous reset while stalled
        rst = 1'b1;
        #1;
        chk("arst_valid", 32'(if_valid), 32'd0);
        chk("arst_pc", if_pc, 32'd0);
        chk("arst_addr", imem_addr, 32'd0);

        // redirect while if_pc=4
        do_reset();
        sb_q.push_back(32'd0);
        sb_q.push_back(32'd4);
        sb_q.push_back(32'h20);
        sb_q.push_back(32'h24);
        step();
        step();
        step();
        redirect_valid = 1'b1;
        redirect_pc = 32'h20;
        step();
        redirect_valid = 1'b0;
        chk("flush_valid", 32'(if_valid), 32'd0);
        chk("flush_instr", if_instr, NOP);
        chk("flush_addr", imem_addr, 32'h20);
        step();
        chk("tgt_pc", if_pc, 32'h20);
        chk("tgt_instr", if_instr, instr_at(32'h20));
        step();
        step();
        id_ready = 1'b0;
        sb_done();

        // halt for 4 cycles with id_ready=1
        do_reset();
        sb_q.push_back(32'd0);
        sb_q.push_back(32'd4);
        sb_q.push_back(32'd8);
        step();
        step();
        step();
        halt = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("halt_valid", 32'(if_valid), 32'd0);
            chk("halt_addr", imem_addr, 32'd8);
        end
        step();
        halt = 1'b0;
        chk("halt_hold", imem_addr, 32'd8);
        step();
        chk("resume_bubble", 32'(if_valid), 32'd0);
        step();
        chk("resume_pc", if_pc, 32'd8);
        step();
        id_ready = 1'b0;
        sb_done();

        // PC wrap at top of address space
        do_reset();
        sb_q.push_back(32'd0);
        sb_q.push_back(32'hFFFF_FFFC);
        sb_q.push_back(32'd0);
        step();
        step();
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        step();
        chk("wrap_pc", if_pc, 32'hFFFF_FFFC);
        chk("wrap_pc4", if_pc_plus4, 32'd0);
        step();
        chk("wrap_next", if_pc, 32'd0);
        step();
        id_ready = 1'b0;
        sb_done();

        // misaligned redirect target
        do_reset();
        sb_q.push_back(32'd0);
`ifndef FETCH_MISALIGN_TRAP_EN
        sb_q.push_back(32'h20);
        sb_q.push_back(32'h24);
`endif
        step();
        step();
        redirect_valid = 1'b1;
        redirect_pc = 32'h22;
        step();
        redirect_valid = 1'b0;
        chk("mis_valid", 32'(if_valid), 32'd0);
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("trap_valid", 32'(trap_valid), 32'd1);
        chk("trap_pc", trap_pc, 32'h22);
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        for (int i = 0; i < 3; i++) begin
            halt = (i == 1);
            step();
            chk("trap_hold_valid", 32'(if_valid), 32'd0);
            chk("trap_hold_addr", imem_addr, 32'd4);
            chk("trap_hold_tv", 32'(trap_valid), 32'd1);
        end
        redirect_valid = 1'b0;
        halt = 1'b0;
        id_ready = 1'b0;
        sb_done();
        do_reset();
        chk("trap_rst", 32'(trap_valid), 32'd0);
        chk("trap_rst_pc", trap_pc, 32'd0);
`else
        chk("mis_addr", imem_addr, 32'h20);
        step();
        chk("mis_pc", if_pc, 32'h20);
        step();
        step();
        id_ready = 1'b0;
        sb_done();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
